// File: rtl/xbar_stream_if.sv
// Stream crossbar bundle: N_IN producer streams in, N_OUT consumer streams out.
// slave is the crossbar's view, master is the view of whoever drives the producers and sinks.
interface xbar_stream_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int WIDTH = 8
);
  localparam int DW = $clog2(N_OUT);
  localparam int SW = $clog2(N_IN);

  logic                   i_cg;
  logic [N_IN-1:0]        i_inValid;
  logic [N_IN-1:0]        o_inReady;
  logic [N_IN*WIDTH-1:0]  i_inData;
  logic [N_IN*DW-1:0]     i_inDest;
  logic [N_IN-1:0]        i_inLast;
  logic [N_OUT-1:0]       o_outValid;
  logic [N_OUT-1:0]       i_outReady;
  logic [N_OUT*WIDTH-1:0] o_outData;
  logic [N_OUT*SW-1:0]    o_outSrc;
  logic [N_OUT-1:0]       o_outLast;
  logic                   o_err;

  modport slave (
    input  i_cg, i_inValid, i_inData, i_inDest, i_inLast, i_outReady,
    output o_inReady, o_outValid, o_outData, o_outSrc, o_outLast, o_err
  );

  modport master (
    output i_cg, i_inValid, i_inData, i_inDest, i_inLast, i_outReady,
    input  o_inReady, o_outValid, o_outData, o_outSrc, o_outLast, o_err
  );
endinterface

// File: rtl/xbar_stream.sv
// Per-beat routed stream crossbar: round-robin arbiter and one register stage per output.
// Define XBAR_STREAM_PKTLOCK_EN to keep an output locked to one source until that packet's last beat.
module xbar_stream #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4,
  parameter int WIDTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  xbar_stream_if.slave bus
);
  localparam int DW = $clog2(N_OUT);
  localparam int SW = $clog2(N_IN);

  logic [N_OUT-1:0]           ld;
  logic [N_OUT-1:0][N_IN-1:0] gnt;
  logic [N_IN-1:0]            oor;
  logic [N_IN-1:0]            in_ready;
  logic                       err_reg;

  // Destinations past N_OUT only exist when N_OUT is not a power of two.
  genvar gi;
  generate
    if ((1 << DW) > N_OUT) begin : g_oor
      for (gi = 0; gi < N_IN; gi++) begin : g_in
        assign oor[gi] = bus.i_inValid[gi] && (bus.i_inDest[gi*DW +: DW] >= DW'(N_OUT));
      end
    end else begin : g_no_oor
      assign oor = '0;
    end
  endgenerate

  always_comb begin
    in_ready = {N_IN{bus.i_cg}} & oor;
    for (int j = 0; j < N_OUT; j++) begin
      in_ready = in_ready | gnt[j];
    end
  end

  assign bus.o_inReady = in_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= bus.i_cg & (|oor);
    end
  end

  assign bus.o_err = err_reg;

  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      logic [N_IN-1:0]  req;
      logic [N_IN-1:0]  elig;
      logic             grant_any;
      logic             gnt_en;
      logic [SW-1:0]    gsel;
      logic [SW-1:0]    cand;
      logic [SW-1:0]    ptr_reg;
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic [SW-1:0]    src_reg;
      logic             last_reg;

      assign ld[gi] = bus.i_cg & (~valid_reg | bus.i_outReady[gi]);

      always_comb begin
        req = '0;
        for (int i = 0; i < N_IN; i++) begin
          req[i] = bus.i_inValid[i] && (bus.i_inDest[i*DW +: DW] == DW'(gi));
        end
      end

`ifdef XBAR_STREAM_PKTLOCK_EN
      logic          lock_reg;
      logic [SW-1:0] lock_src_reg;

      // A locked output only listens to the source whose packet is still open.
      always_comb begin
        elig = req;
        if (lock_reg) begin
          elig = req & (N_IN'(1) << lock_src_reg);
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          lock_reg     <= 1'b0;
          lock_src_reg <= '0;
        end else if (gnt_en) begin
          lock_reg     <= ~bus.i_inLast[gsel];
          lock_src_reg <= gsel;
        end
      end
`else
      assign elig = req;
`endif

      // Search starts at the pointer and wraps, so the last winner has lowest priority.
      always_comb begin
        grant_any = 1'b0;
        gsel      = '0;
        cand      = '0;
        for (int k = 0; k < N_IN; k++) begin
          cand = SW'((int'(ptr_reg) + k) % N_IN);
          if (!grant_any && elig[cand]) begin
            grant_any = 1'b1;
            gsel      = cand;
          end
        end
      end

      assign gnt_en  = grant_any & ld[gi];
      assign gnt[gi] = gnt_en ? (N_IN'(1) << gsel) : '0;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          src_reg   <= '0;
          last_reg  <= 1'b0;
          ptr_reg   <= '0;
        end else if (ld[gi]) begin
          valid_reg <= grant_any;
          if (grant_any) begin
            data_reg <= bus.i_inData[int'(gsel)*WIDTH +: WIDTH];
            src_reg  <= gsel;
            last_reg <= bus.i_inLast[gsel];
            ptr_reg  <= (gsel == SW'(N_IN-1)) ? '0 : gsel + 1'b1;
          end
        end
      end

      assign bus.o_outValid[gi]               = valid_reg;
      assign bus.o_outData[gi*WIDTH +: WIDTH] = data_reg;
      assign bus.o_outSrc[gi*SW +: SW]        = src_reg;
      assign bus.o_outLast[gi]                = last_reg;
    end
  endgenerate
endmodule

// File: tb/tb_xbar_stream.sv
// Bench for xbar_stream: 4x4 and 4x3 instances, directed table plus random traffic vs a beat-level model.
// Expected packet-lock order follows XBAR_STREAM_PKTLOCK_EN.
module tb_xbar_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbar_stream_if #(.N_IN(4), .N_OUT(4), .WIDTH(8)) x1 ();
  xbar_stream_if #(.N_IN(4), .N_OUT(3), .WIDTH(8)) x2 ();

  xbar_stream #(.N_IN(4), .N_OUT(4), .WIDTH(8)) dut1 (.i_clk(clk), .i_rst(rst), .bus(x1.slave));
  xbar_stream #(.N_IN(4), .N_OUT(3), .WIDTH(8)) dut2 (.i_clk(clk), .i_rst(rst), .bus(x2.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Beat-level reference: each output is a one-entry holding slot plus a fairness pointer.
  bit         m_valid [2][4];
  logic [7:0] m_data  [2][4];
  int         m_src   [2][4];
  bit         m_last  [2][4];
  int         m_ptr   [2][4];
  bit         m_lock  [2][4];
  int         m_lsrc  [2][4];
  bit         m_err   [2];
  logic [3:0] m_rdy   [2];
  logic [3:0] rdy_cap [2];

  typedef struct packed {
    logic [3:0]  v;
    logic [7:0]  dest;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  ordy;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_ov;
    logic [7:0]  exp_src;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_err[u] = 1'b0;
      m_rdy[u] = '0;
      for (int j = 0; j < 4; j++) begin
        m_valid[u][j] = 1'b0;
        m_data[u][j]  = '0;
        m_src[u][j]   = 0;
        m_last[u][j]  = 1'b0;
        m_ptr[u][j]   = 0;
        m_lock[u][j]  = 1'b0;
        m_lsrc[u][j]  = 0;
      end
    end
  endfunction

  task automatic model_cycle(input int u, input int n_out, input logic cg, input logic [3:0] v,
                             input logic [7:0] dest, input logic [31:0] data, input logic [3:0] last,
                             input logic [3:0] ordy);
    logic [3:0] r;
    bit any_oor;
    int g;
    int i;
    r = '0;
    any_oor = 1'b0;
    for (int j = 0; j < n_out; j++) begin
      if (cg && (!m_valid[u][j] || ordy[j])) begin
        g = -1;
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr[u][j] + k) % 4;
          if (g < 0 && v[i] && int'(dest[2*i +: 2]) == j && (!m_lock[u][j] || m_lsrc[u][j] == i))
            g = i;
        end
        if (g >= 0) begin
          r[g] = 1'b1;
          m_valid[u][j] = 1'b1;
          m_data[u][j]  = data[8*g +: 8];
          m_src[u][j]   = g;
          m_last[u][j]  = last[g];
          m_ptr[u][j]   = (g + 1) % 4;
`ifdef XBAR_STREAM_PKTLOCK_EN
          m_lock[u][j]  = !last[g];
          m_lsrc[u][j]  = g;
`endif
        end else begin
          m_valid[u][j] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (cg && v[k] && int'(dest[2*k +: 2]) >= n_out) begin
        r[k] = 1'b1;
        any_oor = 1'b1;
      end
    end
    m_err[u] = any_oor;
    m_rdy[u] = r;
  endtask

  function automatic void read_out(input int u, input int j, output logic ov, output logic [7:0] od,
                                   output logic [1:0] os, output logic ol);
    if (u == 0) begin
      ov = x1.o_outValid[j]; od = x1.o_outData[j*8 +: 8]; os = x1.o_outSrc[j*2 +: 2]; ol = x1.o_outLast[j];
    end else begin
      ov = x2.o_outValid[j]; od = x2.o_outData[j*8 +: 8]; os = x2.o_outSrc[j*2 +: 2]; ol = x2.o_outLast[j];
    end
  endfunction

  // One clock: compare registered outputs and combinational readies against the model at the falling edge.
  task automatic tick();
    logic ov;
    logic [7:0] od;
    logic [1:0] os;
    logic ol;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      for (int j = 0; j < (u == 0 ? 4 : 3); j++) begin
        read_out(u, j, ov, od, os, ol);
        chk($sformatf("u%0d out_valid[%0d]", u, j), int'(ov), int'(m_valid[u][j]));
        if (m_valid[u][j]) begin
          chk($sformatf("u%0d out_data[%0d]", u, j), int'(od), int'(m_data[u][j]));
          chk($sformatf("u%0d out_src[%0d]", u, j), int'(os), m_src[u][j]);
          chk($sformatf("u%0d out_last[%0d]", u, j), int'(ol), int'(m_last[u][j]));
        end
      end
    end
    chk("u0 err", int'(x1.o_err), int'(m_err[0]));
    chk("u1 err", int'(x2.o_err), int'(m_err[1]));
    model_cycle(0, 4, x1.i_cg, x1.i_inValid, x1.i_inDest, x1.i_inData, x1.i_inLast, x1.i_outReady);
    model_cycle(1, 3, x2.i_cg, x2.i_inValid, x2.i_inDest, x2.i_inData, x2.i_inLast, {1'b0, x2.i_outReady});
    rdy_cap[0] = x1.o_inReady;
    rdy_cap[1] = x2.o_inReady;
    chk("u0 in_ready", int'(rdy_cap[0]), int'(m_rdy[0]));
    chk("u1 in_ready", int'(rdy_cap[1]), int'(m_rdy[1]));
    $display("cyc %0d u0 cg=%b v=%b dest=%h rdy=%b ov=%b | u1 v=%b dest=%h rdy=%b ov=%b",
             cyc, x1.i_cg, x1.i_inValid, x1.i_inDest, rdy_cap[0], x1.o_outValid,
             x2.i_inValid, x2.i_inDest, rdy_cap[1], x2.o_outValid);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x1.i_cg = 1'b1; x1.i_inValid = '0; x1.i_inData = '0; x1.i_inDest = '0; x1.i_inLast = '1; x1.i_outReady = '1;
    x2.i_cg = 1'b1; x2.i_inValid = '0; x2.i_inData = '0; x2.i_inDest = '0; x2.i_inLast = '1; x2.i_outReady = '1;
  endtask

  initial begin
    int b0;
    bit b1_done;
    int got [$];
    int exp_seq [4];
    logic [3:0] ov_hold;

    //                v        dest    data          last     ordy     exp_rdy  exp_ov   exp_src exp_data
    tbl[0]  = '{4'b1111, 8'hFF, 32'h44332211, 4'b1111, 4'b1111, 4'b0001, 4'b1000, 8'h00, 32'h11000000};
    tbl[1]  = '{4'b0001, 8'h02, 32'h000000A5, 4'b1111, 4'b1111, 4'b0001, 4'b0100, 8'h00, 32'h00A50000};
    tbl[2]  = '{4'b0000, 8'h00, 32'h00000000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 8'h00, 32'h00000000};
    tbl[3]  = '{4'b1011, 8'h45, 32'h40302010, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 8'h00, 32'h00001000};
    tbl[4]  = '{4'b1011, 8'h45, 32'h40302010, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 8'h04, 32'h00002000};
    tbl[5]  = '{4'b1011, 8'h45, 32'h40302010, 4'b1111, 4'b1111, 4'b1000, 4'b0010, 8'h0C, 32'h00004000};
    tbl[6]  = '{4'b1011, 8'h45, 32'h40302010, 4'b1111, 4'b1111, 4'b0001, 4'b0010, 8'h00, 32'h00001000};
    tbl[7]  = '{4'b1011, 8'h45, 32'h40302010, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 8'h04, 32'h00002000};
    tbl[8]  = '{4'b1011, 8'h45, 32'h40302010, 4'b1111, 4'b1111, 4'b1000, 4'b0010, 8'h0C, 32'h00004000};
    tbl[9]  = '{4'b1111, 8'h39, 32'h40302010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 8'h93, 32'h30201040};
    tbl[10] = '{4'b1111, 8'h39, 32'h40302010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 8'h93, 32'h30201040};

    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset while outputs and the error pulse are live.
    x1.i_inValid = 4'b0011; x1.i_inDest = 8'h04;
    x2.i_inValid = 4'b0100; x2.i_inDest = 8'h30;
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("reset u0 out_valid", int'(x1.o_outValid), 0);
    chk("reset u1 out_valid", int'(x2.o_outValid), 0);
    chk("reset u1 err", int'(x2.o_err), 0);
    chk("reset u0 err", int'(x1.o_err), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 11; t++) begin
      x1.i_inValid = tbl[t].v; x1.i_inDest = tbl[t].dest; x1.i_inData = tbl[t].data;
      x1.i_inLast = tbl[t].last; x1.i_outReady = tbl[t].ordy;
      tick();
      chk($sformatf("vec%0d in_ready", t), int'(rdy_cap[0]), int'(tbl[t].exp_rdy));
      chk($sformatf("vec%0d out_valid", t), int'(x1.o_outValid), int'(tbl[t].exp_ov));
      for (int j = 0; j < 4; j++) begin
        if (tbl[t].exp_ov[j]) begin
          chk($sformatf("vec%0d src[%0d]", t, j), int'(x1.o_outSrc[j*2 +: 2]), int'(tbl[t].exp_src[j*2 +: 2]));
          chk($sformatf("vec%0d data[%0d]", t, j), int'(x1.o_outData[j*8 +: 8]), int'(tbl[t].exp_data[j*8 +: 8]));
        end
      end
    end

    // Backpressure on output 1: held beat stays put, then drain and refill in one cycle.
    idle_inputs();
    x1.i_inValid = 4'b0100; x1.i_inDest = 8'h10; x1.i_inData = 32'h00330000;
    tick();
    chk("bp accept", int'(rdy_cap[0][2]), 1);
    x1.i_inData = 32'h00440000;
    x1.i_outReady = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp stall%0d ready", k), int'(rdy_cap[0][2]), 0);
      chk($sformatf("bp stall%0d valid", k), int'(x1.o_outValid[1]), 1);
      chk($sformatf("bp stall%0d data", k), int'(x1.o_outData[15:8]), 8'h33);
      chk($sformatf("bp stall%0d src", k), int'(x1.o_outSrc[3:2]), 2);
    end
    x1.i_outReady = 4'b1111;
    tick();
    chk("bp release ready", int'(rdy_cap[0][2]), 1);
    chk("bp release data", int'(x1.o_outData[15:8]), 8'h44);
    idle_inputs();
    tick();

    // Clock gate low: nothing accepted, outputs frozen.
    x1.i_inValid = 4'b1111; x1.i_inDest = 8'h39; x1.i_inData = 32'h0D0C0B0A;
    tick();
    ov_hold = x1.o_outValid;
    x1.i_cg = 1'b0;
    x1.i_inData = 32'h1D1C1B1A;
    tick();
    chk("cg ready", int'(rdy_cap[0]), 0);
    chk("cg out_valid hold", int'(x1.o_outValid), int'(ov_hold));
    chk("cg data hold", int'(x1.o_outData[7:0]), 8'h0D);
    idle_inputs();
    tick();

    // Packet of 3 from input 0 racing a single beat from input 1 to output 0.
    b0 = 0;
    b1_done = 1'b0;
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      x1.i_inValid = {2'b00, !b1_done, b0 < 3};
      x1.i_inDest = 8'h00;
      x1.i_inData = {16'h0, 8'hD0, 8'(8'hC0 + b0)};
      x1.i_inLast = {3'b111, b0 == 2};
      tick();
      if (rdy_cap[0][0]) b0++;
      if (rdy_cap[0][1]) b1_done = 1'b1;
      if (x1.o_outValid[0]) got.push_back(int'(x1.o_outSrc[1:0]));
    end
`ifdef XBAR_STREAM_PKTLOCK_EN
    exp_seq = '{0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 0};
`endif
    chk("pkt beats delivered", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      chk($sformatf("pkt src%0d", k), got[k], exp_seq[k]);
    end
    idle_inputs();
    tick();

    // Out-of-range destinations on the 3-output instance.
    x2.i_inValid = 4'b0001; x2.i_inDest = 8'h03;
    tick();
    chk("oor single ready", int'(rdy_cap[1]), 4'b0001);
    chk("oor single err", int'(x2.o_err), 1);
    idle_inputs();
    tick();
    chk("oor err drop", int'(x2.o_err), 0);
    x2.i_inValid = 4'b0111; x2.i_inDest = 8'h2F; x2.i_inData = 32'h00771100;
    tick();
    chk("oor multi ready", int'(rdy_cap[1]), 4'b0111);
    chk("oor multi err", int'(x2.o_err), 1);
    chk("oor good beat", int'(x2.o_outData[23:16]), 8'h77);
    idle_inputs();
    tick();
    chk("oor multi err once", int'(x2.o_err), 0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      x1.i_cg = ($urandom_range(0, 9) != 0);
      x1.i_inValid = 4'($urandom);
      x1.i_inDest = 8'($urandom);
      x1.i_inData = $urandom;
      x1.i_inLast = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      x1.i_outReady = 4'($urandom) | 4'($urandom);
      x2.i_cg = ($urandom_range(0, 9) != 0);
      x2.i_inValid = 4'($urandom);
      x2.i_inDest = 8'($urandom);
      x2.i_inData = $urandom;
      x2.i_inLast = 4'($urandom);
      x2.i_outReady = 3'($urandom) | 3'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
